// File: rtl/sprite_renderer.sv
// Frame renderer: erases and redraws both ships, then the cooldown bar, as a stream of single-pixel plots.
// Build option: define SPRITE_RENDERER_COOLDOWN_BAR_EN to include the DRAW_BAR phase.
module sprite_renderer #(
    parameter int SPRITE_W  = 8,
    parameter int SPRITE_H  = 4,
    parameter int USER_Y    = 112,
    parameter int ENEMY_Y   = 4,
    parameter int BAR_Y     = 119,
    parameter int BAR_SCALE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] user_x,
    input  logic [7:0] enemy_x,
    input  logic [3:0] gun_cooldown,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam int                CNT_W    = 10;
    localparam logic [CNT_W-1:0]  LAST_COL = CNT_W'(SPRITE_W - 1);
    localparam logic [2:0]        LAST_ROW = 3'(SPRITE_H - 1);
    localparam logic [6:0]        USER_Y7  = 7'(USER_Y);
    localparam logic [6:0]        ENEMY_Y7 = 7'(ENEMY_Y);
    localparam logic [8:0]        X_LIMIT  = 9'd160;
`ifdef SPRITE_RENDERER_COOLDOWN_BAR_EN
    localparam logic [CNT_W-1:0]  LAST_BAR = CNT_W'(15 * BAR_SCALE - 1);
    localparam logic [6:0]        BAR_Y7   = 7'(BAR_Y);
`else
    localparam int                unused_bar_cfg = BAR_Y + BAR_SCALE;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE_USER,
        S_ERASE_ENEMY,
        S_DRAW_USER,
        S_DRAW_ENEMY,
        S_DRAW_BAR,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [2:0]       row_q, row_d;

    logic [7:0]       user_q, enemy_q;
    logic [7:0]       prev_user_q, prev_enemy_q;

    logic [7:0]       x_q, x_d;
    logic [6:0]       y_q, y_d;
    logic [2:0]       colour_q, colour_d;
    logic             plot_q, plot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             start;

`ifdef SPRITE_RENDERER_COOLDOWN_BAR_EN
    logic [3:0]       cool_q;
    logic [CNT_W-1:0] bar_fill;
    assign bar_fill = CNT_W'(cool_q) * CNT_W'(BAR_SCALE);
`else
    logic             unused_cooldown;
    assign unused_cooldown = ^gun_cooldown;
`endif

    assign start = (state_q == S_IDLE) && frame_tick;

    function automatic state_t ship_next(input state_t s);
        case (s)
            S_ERASE_USER:  return S_ERASE_ENEMY;
            S_ERASE_ENEMY: return S_DRAW_USER;
            S_DRAW_USER:   return S_DRAW_ENEMY;
`ifdef SPRITE_RENDERER_COOLDOWN_BAR_EN
            S_DRAW_ENEMY:  return S_DRAW_BAR;
`else
            S_DRAW_ENEMY:  return S_DONE;
`endif
            default:       return S_DONE;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Scan sequencing: column fastest, then row, then next phase with no gap cycle.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = S_ERASE_USER;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            S_ERASE_USER, S_ERASE_ENEMY, S_DRAW_USER, S_DRAW_ENEMY: begin
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = ship_next(state_q);
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    col_d = col_q + CNT_W'(1);
                end
            end
`ifdef SPRITE_RENDERER_COOLDOWN_BAR_EN
            S_DRAW_BAR: begin
                if (col_q == LAST_BAR) begin
                    col_d   = '0;
                    state_d = S_DONE;
                end else begin
                    col_d = col_q + CNT_W'(1);
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are derived from the next scan position so they land in the register one edge early.
    logic [7:0] base;
    logic [6:0] top;
    logic [2:0] pcol;
    logic       scan;
    logic [8:0] sum9;

    always_comb begin
        base = 8'd0;
        top  = 7'd0;
        pcol = 3'b000;
        scan = 1'b1;
        case (state_d)
            S_ERASE_USER: begin
                base = prev_user_q;
                top  = USER_Y7;
            end
            S_ERASE_ENEMY: begin
                base = prev_enemy_q;
                top  = ENEMY_Y7;
            end
            S_DRAW_USER: begin
                base = user_q;
                top  = USER_Y7;
                pcol = 3'b010;
            end
            S_DRAW_ENEMY: begin
                base = enemy_q;
                top  = ENEMY_Y7;
                pcol = 3'b100;
            end
`ifdef SPRITE_RENDERER_COOLDOWN_BAR_EN
            S_DRAW_BAR: begin
                top  = BAR_Y7;
                pcol = (col_d < bar_fill) ? 3'b110 : 3'b000;
            end
`endif
            default: scan = 1'b0;
        endcase

        sum9     = {1'b0, base} + col_d[8:0];
        x_d      = scan ? sum9[7:0] : 8'd0;
        y_d      = scan ? (top + {4'b0000, row_d}) : 7'd0;
        colour_d = scan ? pcol : 3'b000;
        plot_d   = scan && (sum9 < X_LIMIT);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            user_q       <= '0;
            enemy_q      <= '0;
            prev_user_q  <= '0;
            prev_enemy_q <= '0;
`ifdef SPRITE_RENDERER_COOLDOWN_BAR_EN
            cool_q       <= '0;
`endif
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            if (start) begin
                user_q  <= user_x;
                enemy_q <= enemy_x;
`ifdef SPRITE_RENDERER_COOLDOWN_BAR_EN
                cool_q  <= gun_cooldown;
`endif
            end
            if (state_q == S_DONE) begin
                prev_user_q  <= user_q;
                prev_enemy_q <= enemy_q;
            end
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: a frame-level model queues the expected per-cycle output stream.
module tb_sprite_renderer;

    localparam int SW = 8;
    localparam int SH = 4;
    localparam int UY = 112;
    localparam int EY = 4;
    localparam int BY = 119;
    localparam int BS = 4;
`ifdef SPRITE_RENDERER_COOLDOWN_BAR_EN
    localparam int BAR_LEN = 15 * BS;
`else
    localparam int BAR_LEN = 0;
`endif
    localparam int N = 4 * SW * SH + BAR_LEN;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic [7:0] user_x = 8'd0;
    logic [7:0] enemy_x = 8'd0;
    logic [3:0] gun_cooldown = 4'd0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    sprite_renderer #(
        .SPRITE_W(SW), .SPRITE_H(SH), .USER_Y(UY), .ENEMY_Y(EY), .BAR_Y(BY), .BAR_SCALE(BS)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .user_x(user_x), .enemy_x(enemy_x), .gun_cooldown(gun_cooldown),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit plot;
        bit done;
        bit chk_x;
        bit chk_yc;
        int x;
        int y;
        int colour;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   m_prev_user = 0;
    int   m_prev_enemy = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, expv, $time);
        end
    endtask

    // Reference: the frame is four rectangles plus an optional bar, one entry per cycle, then the done cycle.
    task automatic model_frame(input int ux, input int ex, input int cd);
        int   bases[4];
        int   tops[4];
        int   cols[4];
        exp_t e;
        bases = '{m_prev_user, m_prev_enemy, ux, ex};
        tops  = '{UY, EY, UY, EY};
        cols  = '{0, 0, 2, 4};
        for (int p = 0; p < 4; p++)
            for (int r = 0; r < SH; r++)
                for (int c = 0; c < SW; c++) begin
                    int xx;
                    xx       = bases[p] + c;
                    e.plot   = (xx < 160);
                    e.done   = 1'b0;
                    e.chk_x  = 1'b1;
                    e.chk_yc = e.plot;
                    e.x      = xx % 256;
                    e.y      = tops[p] + r;
                    e.colour = cols[p];
                    exp_q.push_back(e);
                end
        for (int c = 0; c < BAR_LEN; c++) begin
            e.plot   = 1'b1;
            e.done   = 1'b0;
            e.chk_x  = 1'b1;
            e.chk_yc = 1'b1;
            e.x      = c;
            e.y      = BY;
            e.colour = (c < cd * BS) ? 6 : 0;
            exp_q.push_back(e);
        end
        e.plot   = 1'b0;
        e.done   = 1'b1;
        e.chk_x  = 1'b0;
        e.chk_yc = 1'b0;
        e.x      = 0;
        e.y      = 0;
        e.colour = 0;
        exp_q.push_back(e);
        m_prev_user  = ux;
        m_prev_enemy = ex;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && reset) begin
            if (busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_busy", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_plot_done", int'({plot, done}), int'({e.plot, e.done}));
                    if (e.chk_x) chk("pixel_x", int'(x), e.x);
                    if (e.chk_yc) begin
                        chk("pixel_y", int'(y), e.y);
                        chk("pixel_colour", int'(colour), e.colour);
                    end
                end
            end else begin
                chk("idle_quiet", int'({plot, done}), 0);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", int'({x, y, colour, plot, busy, done}), 0);
        exp_q.delete();
        m_prev_user  = 0;
        m_prev_enemy = 0;
        @(negedge clk);
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic frame(input int ux, input int ex, input int cd);
        @(negedge clk);
        user_x       = 8'(ux);
        enemy_x      = 8'(ex);
        gun_cooldown = 4'(cd);
        frame_tick   = 1'b1;
        model_frame(ux, ex, cd);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        chk("start_latency", int'(busy), 1);
        for (int i = 0; i < N + 1; i++) begin
            @(negedge clk);
            if (i == N) chk("done_timing", int'(done), 1);
            user_x       = 8'($urandom);
            enemy_x      = 8'($urandom);
            gun_cooldown = 4'($urandom);
            frame_tick   = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        chk("frame_end_idle", int'({busy, done}), 0);
    endtask

    task automatic held_frames(input int nframes);
        for (int f = 0; f < nframes; f++) begin
            @(negedge clk);
            if (f > 0) chk("held_gap_idle", int'(busy), 0);
            user_x       = 8'($urandom);
            enemy_x      = 8'($urandom);
            gun_cooldown = 4'($urandom);
            frame_tick   = 1'b1;
            model_frame(int'(user_x), int'(enemy_x), int'(gun_cooldown));
            for (int i = 0; i < N + 1; i++) begin
                @(negedge clk);
                user_x       = 8'($urandom);
                enemy_x      = 8'($urandom);
                gun_cooldown = 4'($urandom);
            end
        end
        frame_tick = 1'b0;
        @(posedge clk);
    endtask

    task automatic reset_mid_frame(input int pix);
        @(negedge clk);
        user_x     = 8'd90;
        enemy_x    = 8'd100;
        frame_tick = 1'b1;
        model_frame(90, 100, 0);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        repeat (pix) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("reset_midframe_outputs", int'({x, y, colour, plot, busy, done}), 0);
        exp_q.delete();
        m_prev_user  = 0;
        m_prev_enemy = 0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, queue depth %0d", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        frame(20, 50, 0);
        frame(24, 50, 0);
        frame(24, 156, 0);
        frame(24, 156, 5);
        held_frames(3);
        reset_mid_frame(70);
        frame(30, 40, 3);
        frame(153, 159, 15);
        frame(160, 255, 1);
        for (int k = 0; k < 20; k++)
            frame(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

- Consumes the per-frame game state from the datapath: `user_x`, `enemy_x` and `gun_cooldown`.
- Turns that state into a stream of single-pixel writes for the VGA adapter's plot port.
- Each frame it erases both ships at their previously drawn positions, redraws them at the new positions, and then redraws the gun-cooldown bar.
- It is started by a frame tick from the control FSM and reports completion with a one-cycle `done` pulse.

## Interface

Parameters:
- `SPRITE_W`, 8: ship width in pixels (1–16).
- `SPRITE_H`, 4: ship height in pixels (1–8).
- `USER_Y`, 112: top row of the user ship.
- `ENEMY_Y`, 4: top row of the enemy ship.
- `BAR_Y`, 119: row of the cooldown bar.
- `BAR_SCALE`, 4: pixels per cooldown unit; bar length is `15*BAR_SCALE`.

Ports:
- `clk` input 1: system clock (50 MHz).
- `reset` input 1: asynchronous, active-low reset.
- `frame_tick` input 1: request to start a frame; sampled only while idle.
- `user_x` input 8: left column of the user ship.
- `enemy_x` input 8: left column of the enemy ship.
- `gun_cooldown` input 4: cooldown level, 0–15.
- `x` output 8: pixel column.
- `y` output 7: pixel row.
- `colour` output 3: pixel colour, RGB.
- `plot` output 1: write strobe for (`x`, `y`, `colour`) in the current cycle.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse after the last pixel of a frame.

## Operation

- States, in order: IDLE, ERASE_USER, ERASE_ENEMY, DRAW_USER, DRAW_ENEMY, DRAW_BAR, DONE, then back to IDLE.
- Start of frame: `frame_tick` high in IDLE →
  - latch `user_x`, `enemy_x` and `gun_cooldown`;
  - enter ERASE_USER.
- `frame_tick` while not in IDLE is ignored (not queued). Input changes during a frame are ignored.
- Ship phases: scan `SPRITE_W`×`SPRITE_H` pixels in row-major order (column fastest), one pixel per cycle. Pixel (c, r) is at `x = base + c`, `y = top + r`.
  - ERASE_USER: base = `prev_user`, top = `USER_Y`, colour 000.
  - ERASE_ENEMY: base = `prev_enemy`, top = `ENEMY_Y`, colour 000.
  - DRAW_USER: base = latched `user_x`, top = `USER_Y`, colour 010 (green).
  - DRAW_ENEMY: base = latched `enemy_x`, top = `ENEMY_Y`, colour 100 (red).
- DRAW_BAR: columns 0 to `15*BAR_SCALE-1` on `BAR_Y`.
  - Colour 110 (yellow) for columns below `cooldown*BAR_SCALE`, colour 000 otherwise.
- Clipping:
  - `base + c` is computed 9 bits wide.
  - If the result is ≥160, `plot` is 0 for that cycle, but the scan still consumes the cycle.
  - `x` carries the low 8 bits of the result.
- DONE:
  - `prev_user` ← latched `user_x`, `prev_enemy` ← latched `enemy_x`;
  - `done` = 1 for that cycle;
  - next state is IDLE.
- `plot` is 0 in IDLE and DONE, and 1 on every unclipped scan cycle.

## Timing

- Reset values:
  - state IDLE;
  - `x`, `y`, `colour`, `plot`, `busy`, `done` all 0;
  - `prev_user` and `prev_enemy` 0.
  - The first frame after reset therefore erases at column 0.
- All outputs are registered.
- Frame timing, with `frame_tick` sampled at edge T:
  - the first pixel appears in cycle T+1;
  - pixels are contiguous, with no gap cycles between phases;
  - N = `4*SPRITE_W*SPRITE_H + 15*BAR_SCALE`, which is 188 with default parameters;
  - the last pixel is in cycle T+N;
  - `done` is high in cycle T+N+1;
  - `busy` is high for cycles T+1 through T+N+1;
  - the earliest next accepted tick is at cycle T+N+2.
- Reset asserted mid-frame:
  - everything returns to reset values immediately;
  - no partial `done` pulse;
  - `prev_*` is cleared.

## Configuration

- Macro: `SPRITE_RENDERER_COOLDOWN_BAR_EN`.
- Defined: DRAW_BAR is present and N includes `15*BAR_SCALE`.
- Undefined:
  - DRAW_BAR is removed and DRAW_ENEMY goes directly to DONE;
  - N = `4*SPRITE_W*SPRITE_H`, which is 128 with default parameters;
  - `gun_cooldown` is unused.

## Test plan

1. Reset, then tick with `user_x`=20, `enemy_x`=50 and `gun_cooldown`=0:
   - expect 188 `plot` pulses, of which 128 are ship pixels plus 60 bar pixels, all bar pixels 000;
   - the user sprite is green over x 20–27, y 112–115;
   - `done` occurs at T+189.
2. Second tick with `user_x`=24:
   - the erase pass is 000 over x 20–27, y 112–115;
   - the draw pass is green over x 24–31.
3. Tick with `enemy_x`=156:
   - in the DRAW_ENEMY phase, columns 156–159 are plotted;
   - columns 160–163 have `plot`=0, and the phase still lasts 32 cycles.
4. `gun_cooldown`=5:
   - bar columns 0–19 are 110;
   - bar columns 20–59 are 000.
5. `frame_tick` held high throughout:
   - consecutive frames start every N+2 cycles;
   - no tick is accepted while `busy`.
6. Reset asserted at pixel 70:
   - all outputs are 0 the same cycle;
   - the next frame's erase pass targets x 0–7.
